// File: rtl/channel_layout_sequencer.sv
// Per-frame channel layout sequencer: latches channel_enable, counts enabled channels, divides
// the channel area height iteratively, then tracks channel boundaries line by line.
module channel_layout_sequencer #(
  parameter int unsigned MAX_CHAN_COUNT = 10,
  parameter int unsigned OFFSET         = 0,
  parameter int unsigned VGA_VER_RES    = 480,
  localparam int unsigned W = $clog2(VGA_VER_RES),
  localparam int unsigned C = $clog2(MAX_CHAN_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic [W-1:0]              pixel_row,
  output logic                      layout_valid,
  output logic [C:0]                channel_count,
  output logic [W-1:0]              channel_height,
  output logic                      is_channel,
  output logic [C-1:0]              channel_number,
  output logic [W-1:0]              channel_offset
);

  localparam int unsigned MaxSteps = (MAX_CHAN_COUNT > W) ? MAX_CHAN_COUNT : W;
  localparam int unsigned SW       = $clog2(MaxSteps + 1);

  localparam logic [W-1:0] OffsetRow  = W'(OFFSET);
  localparam logic [W:0]   OffsetExt  = (W+1)'(OFFSET);
  localparam logic [W-1:0] AreaHeight = W'(VGA_VER_RES - OFFSET);

  typedef enum logic [1:0] {StIdle, StCount, StDivide, StReady} state_e;

  state_e                    state_q, state_d;
  logic [MAX_CHAN_COUNT-1:0] en_q, en_d;
  logic [SW-1:0]             idx_q, idx_d;
  logic [C:0]                count_q, count_d;
  logic [W-1:0]              rem_q, rem_d;
  logic [W-1:0]              dvd_q, dvd_d;
  logic [W-1:0]              quot_q, quot_d;
  logic [W-1:0]              height_q, height_d;
  logic [C:0]                vis_q, vis_d;
  logic [W:0]                boundary_q, boundary_d;
  logic                      is_chan_q, is_chan_d;
  logic [C-1:0]              chan_num_q, chan_num_d;
  logic [W-1:0]              chan_off_q, chan_off_d;

  logic                      en_bit;
  logic [W:0]                rem_shift;
  logic [W:0]                divisor;
  logic                      ge;
  logic [W:0]                row_ext;
  logic [W:0]                row_minus_off;
  logic [W:0]                height_ext;
  logic [C-1:0]              first_bit;
  logic [C-1:0]              next_bit;
  logic                      next_found;

  // Lowest set enable bit, and lowest set bit strictly above the current channel.
  always_comb begin
    first_bit  = '0;
    next_bit   = '0;
    next_found = 1'b0;
    for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        first_bit = C'(i);
        if (i > int'(chan_num_q)) begin
          next_bit   = C'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    idx_d      = idx_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quot_d     = quot_q;
    height_d   = height_q;
    vis_d      = vis_q;
    boundary_d = boundary_q;
    is_chan_d  = is_chan_q;
    chan_num_d = chan_num_q;
    chan_off_d = chan_off_q;

    en_bit        = |(en_q & (MAX_CHAN_COUNT'(1) << idx_q));
    rem_shift     = {rem_q, dvd_q[W-1]};
    divisor       = (W+1)'(count_q);
    ge            = (rem_shift >= divisor);
    row_ext       = {1'b0, pixel_row};
    row_minus_off = row_ext - OffsetExt;
    height_ext    = {1'b0, height_q};

    unique case (state_q)
      StIdle: begin
      end
      StCount: begin
        count_d = count_q + (C+1)'(en_bit);
        idx_d   = idx_q + 1'b1;
        if (idx_q == SW'(MAX_CHAN_COUNT - 1)) begin
          idx_d = '0;
          if (count_d != '0) begin
            state_d = StDivide;
            rem_d   = '0;
            dvd_d   = AreaHeight;
            quot_d  = '0;
          end else begin
            state_d  = StReady;
            height_d = '0;
          end
        end
      end
      StDivide: begin
        // Restoring division, MSB first: one quotient bit per cycle.
        rem_d  = ge ? W'(rem_shift - divisor) : W'(rem_shift);
        dvd_d  = dvd_q << 1;
        quot_d = (quot_q << 1) | W'(ge);
        idx_d  = idx_q + 1'b1;
        if (idx_q == SW'(W - 1)) begin
          idx_d    = '0;
          state_d  = StReady;
          height_d = quot_d;
        end
      end
      StReady: begin
        if (line_start) begin
          if (row_minus_off[W]) begin
            is_chan_d = 1'b0;
          end else if (pixel_row == OffsetRow) begin
            vis_d      = '0;
            chan_off_d = OffsetRow;
            boundary_d = OffsetExt + height_ext;
            if (count_q != '0) begin
              chan_num_d = first_bit;
            end
            is_chan_d = (count_q != '0);
          end else begin
            // Saturate at count so remainder rows stay outside every channel.
            if (row_ext >= boundary_q && vis_q < count_q) begin
              vis_d      = vis_q + 1'b1;
              chan_off_d = boundary_q[W-1:0];
              boundary_d = boundary_q + height_ext;
              if (next_found) begin
                chan_num_d = next_bit;
              end
            end
            is_chan_d = (count_q != '0) && (vis_d < count_q);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (line_start && state_q != StReady) begin
      is_chan_d = 1'b0;
    end

    if (frame_start) begin
      state_d    = StCount;
      en_d       = channel_enable;
      idx_d      = '0;
      count_d    = '0;
      is_chan_d  = 1'b0;
      vis_d      = '0;
      boundary_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      en_q       <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quot_q     <= '0;
      height_q   <= '0;
      vis_q      <= '0;
      boundary_q <= '0;
      is_chan_q  <= 1'b0;
      chan_num_q <= '0;
      chan_off_q <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quot_q     <= quot_d;
      height_q   <= height_d;
      vis_q      <= vis_d;
      boundary_q <= boundary_d;
      is_chan_q  <= is_chan_d;
      chan_num_q <= chan_num_d;
      chan_off_q <= chan_off_d;
    end
  end

  assign layout_valid   = (state_q == StReady);
  assign channel_count  = count_q;
  assign channel_height = height_q;
  assign is_channel     = is_chan_q;
  assign channel_number = chan_num_q;
  assign channel_offset = chan_off_q;

endmodule

// File: tb/tb_channel_layout_sequencer.sv
// Randomized bench for channel_layout_sequencer against a row-to-channel reference model.
module tb_channel_layout_sequencer;

  localparam int unsigned N      = 10;
  localparam int unsigned OFFSET = 0;
  localparam int unsigned RES    = 480;
  localparam int unsigned W      = $clog2(RES);
  localparam int unsigned C      = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] channel_enable;
  logic         frame_start;
  logic         line_start;
  logic [W-1:0] pixel_row;
  logic         layout_valid;
  logic [C:0]   channel_count;
  logic [W-1:0] channel_height;
  logic         is_channel;
  logic [C-1:0] channel_number;
  logic [W-1:0] channel_offset;

  channel_layout_sequencer #(
    .MAX_CHAN_COUNT(N),
    .OFFSET        (OFFSET),
    .VGA_VER_RES   (RES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .channel_enable(channel_enable),
    .frame_start   (frame_start),
    .line_start    (line_start),
    .pixel_row     (pixel_row),
    .layout_valid  (layout_valid),
    .channel_count (channel_count),
    .channel_height(channel_height),
    .is_channel    (is_channel),
    .channel_number(channel_number),
    .channel_offset(channel_offset)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference layout: list of enabled channel indices, count and height.
  int ch_list[$];
  int m_n;
  int m_h;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_model(input logic [N-1:0] en);
    ch_list.delete();
    for (int i = 0; i < int'(N); i++) begin
      if (en[i]) ch_list.push_back(i);
    end
    m_n = ch_list.size();
    m_h = (m_n != 0) ? (RES - OFFSET) / m_n : 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  layout_valid,   0);
    check({tag, "_count"},  channel_count,  0);
    check({tag, "_height"}, channel_height, 0);
    check({tag, "_ischan"}, is_channel,     0);
    check({tag, "_num"},    channel_number, 0);
    check({tag, "_off"},    channel_offset, 0);
  endtask

  // Pulse frame_start (optionally with a coincident line_start) and check the latency window.
  task automatic run_frame(input logic [N-1:0] en, input bit scramble, input bit with_line);
    int lat;
    @(posedge clk) #1;
    channel_enable = en;
    frame_start    = 1'b1;
    if (with_line) begin
      line_start = 1'b1;
      pixel_row  = '0;
    end
    @(posedge clk) #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    set_model(en);
    lat = (m_n != 0) ? 1 + N + W : 1 + N;
    for (int k = 1; k <= lat; k++) begin
      if (scramble) channel_enable = N'($urandom);
      @(negedge clk);
      check($sformatf("valid_cyc%0d", k), layout_valid, (k == lat) ? 1 : 0);
      if (k == 1) check("ischan_after_fs", is_channel, 0);
      if (k < lat) @(posedge clk) #1;
    end
    check("count", channel_count, m_n);
    check("height", channel_height, m_h);
  endtask

  task automatic track_lines(input int rows, input bit scramble);
    int k;
    for (int r = 0; r < rows; r++) begin
      @(posedge clk) #1;
      line_start = 1'b1;
      pixel_row  = W'(r);
      if (scramble && ($urandom % 8 == 0)) channel_enable = N'($urandom);
      @(posedge clk) #1;
      line_start = 1'b0;
      @(negedge clk);
      k = (m_h != 0) ? (r - OFFSET) / m_h : 0;
      if (m_n != 0 && k < m_n) begin
        check($sformatf("ischan_r%0d", r), is_channel, 1);
        check($sformatf("num_r%0d", r), channel_number, ch_list[k]);
        check($sformatf("off_r%0d", r), channel_offset, OFFSET + k * m_h);
      end else begin
        check($sformatf("ischan_r%0d", r), is_channel, 0);
      end
      check("valid_hold", layout_valid, 1);
    end
  endtask

  initial begin
    logic [N-1:0] a_en;
    logic [N-1:0] b_en;
    rst_n          = 1'b0;
    channel_enable = '0;
    frame_start    = 1'b0;
    line_start     = 1'b0;
    pixel_row      = '0;
    #3;
    check_all_zero("reset");
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_valid", layout_valid, 0);

    run_frame(N'('b0000100101), 1'b0, 1'b0);
    track_lines(RES, 1'b0);

    run_frame(N'('b0001111111), 1'b0, 1'b0);
    track_lines(RES, 1'b0);

    run_frame('0, 1'b0, 1'b0);
    track_lines(RES, 1'b0);

    // Enable changes outside frame_start must be ignored.
    run_frame(N'('b1), 1'b1, 1'b0);
    channel_enable = N'('b11);
    track_lines(RES, 1'b1);

    // Restart during DIVIDE.
    a_en = N'($urandom) | N'('b1);
    b_en = N'($urandom);
    @(posedge clk) #1;
    channel_enable = a_en;
    frame_start    = 1'b1;
    @(posedge clk) #1;
    frame_start = 1'b0;
    repeat (13) begin
      @(negedge clk);
      check("valid_before_restart", layout_valid, 0);
      @(posedge clk) #1;
    end
    run_frame(b_en, 1'b0, 1'b0);
    track_lines(RES, 1'b0);

    // Random frames; one starts with a coincident line_start.
    for (int f = 0; f < 4; f++) begin
      run_frame(N'($urandom), 1'($urandom), (f == 0) ? 1'b1 : 1'b0);
      track_lines(RES, 1'($urandom));
    end

    // Reset mid-line.
    run_frame(N'('b1010), 1'b0, 1'b0);
    track_lines(60, 1'b0);
    @(posedge clk) #1;
    line_start = 1'b1;
    pixel_row  = W'(60);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_midline");
    line_start = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-DIVIDE.
    @(posedge clk) #1;
    channel_enable = N'('b111);
    frame_start    = 1'b1;
    @(posedge clk) #1;
    frame_start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_middiv");
    @(negedge clk) rst_n = 1'b1;

    // No activity after release until frame_start, even with line_start pulses.
    for (int i = 0; i < 30; i++) begin
      @(posedge clk) #1;
      line_start = (i % 2 == 0);
      pixel_row  = W'(i);
      @(negedge clk);
      check("post_rst_valid", layout_valid, 0);
      check("post_rst_ischan", is_channel, 0);
      check("post_rst_count", channel_count, 0);
    end
    line_start = 1'b0;

    run_frame(N'($urandom), 1'b0, 1'b0);
    track_lines(RES, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
